// File: rtl/mul_div_unit.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
// One multiplier/quotient bit per CALC cycle; FIN applies signs and writes HI/LO.
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO writes accepted
// S_CALC | one shift-add / shift-subtract step per cycle
// S_FIN  | sign fix-up, HI/LO write, done pulse on exit
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_a_raw;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_signed;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  // Magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude.
  assign w_signed = ~op[0];
  assign w_mag_a  = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_mag_b  = (w_signed && b[WIDTH-1]) ? -b : b;

  // Multiply: accumulator high half gathers partial sums, low half holds the
  // multiplier and is consumed LSB first as the product shifts in.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: high half is the partial remainder, low half shifts the dividend
  // out and the quotient in. Remainder stays below the divisor, so only the
  // low WIDTH bits of the difference are needed.
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_qbit      = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
  assign w_div_next  = {(w_qbit ? w_div_diff : w_div_shift[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_qbit};

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  assign w_res_hi = !r_is_div ? w_prod[2*WIDTH-1:WIDTH] :
                    r_div_zero ? r_a_raw : w_rem;
  assign w_res_lo = !r_is_div ? w_prod[WIDTH-1:0] :
                    r_div_zero ? {WIDTH{1'b1}} : w_quo;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
      r_opnd     <= '0;
      r_a_raw    <= '0;
      r_acc      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_is_div   <= op[1];
            r_neg_res  <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_rem  <= w_signed & a[WIDTH-1];
            r_div_zero <= op[1] & (b == '0);
            r_opnd     <= op[1] ? w_mag_b : w_mag_a;
            r_a_raw    <= a;
            r_acc      <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
            r_cnt      <= CNT_LOAD;
            r_busy     <= 1'b1;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          if (r_cnt == '0) r_state <= S_FIN;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_FIN: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_dbz   <= r_div_zero;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: the driver pushes hand-computed results,
// a negedge monitor pops and checks them whenever done is seen.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Called at a negedge: start is sampled by the next posedge (cycle 0 = now).
  task automatic issue(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    exp_t e;
    op = o; a = ia; b = ib; start = 1'b1;
    e.hi = ehi; e.lo = elo; e.dbz = edbz; e.due = cyc + 34;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done timeout actual=no_done required=done (cycle %0d)", cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done required=no_done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_hi", hi, e.hi);
        chk("result_lo", lo, e.lo);
        chk("result_dbz", {31'b0, div_by_zero}, {31'b0, e.dbz});
        chk("busy_at_done", {31'b0, busy}, 32'd0);
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // MULTU with explicit latency edges
    issue(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    chk("busy_cycle1", {31'b0, busy}, 32'd1);
    repeat (32) @(negedge clk);
    chk("busy_cycle33", {31'b0, busy}, 32'd1);
    chk("done_cycle33", {31'b0, done}, 32'd0);
    @(negedge clk);
    chk("busy_cycle34", {31'b0, busy}, 32'd0);
    chk("done_cycle34", {31'b0, done}, 32'd1);
    @(negedge clk);
    chk("done_one_pulse", {31'b0, done}, 32'd0);

    // Signed multiply and divide
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    wait_done(); @(negedge clk);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_done(); @(negedge clk);

    // Divide by zero, sticky flag, then signed overflow
    issue(2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    wait_done(); @(negedge clk);
    chk("dbz_held", {31'b0, div_by_zero}, 32'd1);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    wait_done(); @(negedge clk);

    // start and MTHI while busy are ignored
    issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    repeat (4) @(negedge clk);
    op = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);

    // Back-to-back: start in the done cycle, first result held meanwhile
    issue(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
    wait_done();
    issue(2'b11, 32'd50, 32'd8, 32'd2, 32'd6, 1'b0);
    repeat (8) @(negedge clk);
    chk("b2b_hold_hi", hi, 32'd0);
    chk("b2b_hold_lo", lo, 32'd15);
    repeat (24) @(negedge clk);
    chk("b2b_hold_lo_late", lo, 32'd15);
    wait_done(); @(negedge clk);

    // MTHI/MTLO in IDLE
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi_both", hi, 32'hA5A5_A5A5);
    chk("mtlo_both", lo, 32'hA5A5_A5A5);
    lo_we = 1'b1; wdata = 32'h1111_2222;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_only_lo", lo, 32'h1111_2222);
    chk("mtlo_only_hi", hi, 32'hA5A5_A5A5);

    // start together with MTHI: write lands, result overwrites later
    hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    issue(2'b01, 32'h0001_0001, 32'h0001_0001, 32'h0000_0001, 32'h0002_0001, 1'b0);
    hi_we = 1'b0;
    chk("start_mthi_hi", hi, 32'hCAFE_F00D);
    wait_done(); @(negedge clk);

    // Reset in cycle 10 aborts the multiply
    issue(2'b01, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    wait_done(); @(negedge clk);

    begin
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL drain actual=%0d_pending required=0_pending", sb.size());
      end
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multi-cycle multiply/divide responder for the EX stage.
- Accepts MULT/MULTU/DIV/DIVU requests from the pipeline through a start/busy/done handshake and holds results in architectural HI/LO registers.
- Replaces the single-cycle combinational multiply and divide paths in the ALU.
- The hazard unit stalls on busy; MFHI/MFLO read hi/lo directly.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  input  WIDTH  rs operand; multiplicand or dividend
- b  input  WIDTH  rt operand; multiplier or divisor
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when hi/lo take a new result
- div_by_zero  output  1  valid with done; set for DIV/DIVU with b==0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high, one clock, single domain):
  - state=IDLE; hi=0, lo=0; busy=0, done=0, div_by_zero=0; counter=0.
  - Reset during CALC or FIN aborts the operation; no result is written.
- States:
  - IDLE -> CALC on start.
  - CALC -> FIN after 32 iterations.
  - FIN -> IDLE after one cycle.
- Latency, with start sampled high in cycle 0:
  - busy=1 in cycles 1..33 (CALC 1..32, FIN 33).
  - In cycle 34: busy=0, done=1, new hi/lo visible.
  - Total fixed latency is 34 cycles for all ops, including divide by zero.
- Operand capture:
  - On accept, latch op, |a|, |b|, and the result signs.
  - Signed ops take the magnitude; the magnitude of -2^31 is 0x80000000, treated as unsigned.
  - Later changes to a, b or op do not affect the operation.
- Multiply:
  - Radix-2 shift-add over a 64-bit accumulator, one multiplier bit per cycle.
  - FIN negates the 64-bit product if the signs differ.
  - Result: {hi,lo} = full 64-bit product.
- Divide:
  - Restoring shift-subtract, one quotient bit per cycle.
  - FIN applies signs: the quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - Result: lo = quotient, truncated toward zero; hi = remainder.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; div_by_zero=0.
- Divide by zero (b==0, DIV or DIVU):
  - Full latency; lo=0xFFFFFFFF, hi=a as captured; div_by_zero=1 in the done cycle.
  - div_by_zero=0 for every other completion; it holds its value until the next done.
- Handshake:
  - start while busy=1 is ignored.
  - start in the same cycle as done=1 is accepted (state is IDLE).
  - done is high for exactly one cycle per accepted op.
- MTHI/MTLO:
  - hi_we/lo_we take effect only in IDLE; both may fire together.
  - While busy they are ignored, and the pending result overwrites hi/lo.
  - If start and hi_we/lo_we are asserted in the same IDLE cycle, the write takes effect and the operation is accepted; the result later overwrites.
- hi/lo change only on reset, MTHI/MTLO in IDLE, or the FIN->IDLE edge.

Test Plan:
- MULTU a=0xFFFFFFFF, b=2 -> cycle 34: done=1, hi=0x00000001, lo=0xFFFFFFFE, busy low in that same cycle.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=0x12345678, b=0 -> cycle 34: done=1, div_by_zero=1, lo=0xFFFFFFFF, hi=0x12345678; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- start DIVU 100/7, then pulse start with different operands and hi_we=1, wdata=0xDEADBEEF in cycle 5 -> both ignored; cycle 34: lo=14, hi=2; exactly one done pulse.
- Back-to-back: new start asserted in the done cycle -> accepted; second done exactly 34 cycles later; hi/lo of the first result held in between.
- Reset asserted in cycle 10 of a MULTU -> next cycle busy=0, hi=lo=0; no done pulse follows; a fresh op completes normally.
